mc_ctrl: RTL and testbench

- Multicycle control FSM for the MIPS-lite datapath; the producer end of the ALU interface.
- Drives the 4-bit ALU operation code, consumes the ALU `zero` flag, and sequences fetch/decode/execute/memory/writeback.
- Decodes opcode/funct from the instruction register and drives all datapath muxes and write enables.
- Handshakes with the unified instruction/data memory via `mem_ready`.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_ctrl_alu_dec.sv | 24 ++
 rtl/mc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS-lite controller.
// Holds opcode/funct values, ALU control codes, alu_src_b and pc_src mux
// encodings, and the 4-bit controller state encoding.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_HALT     = 4'd13
    } state_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: R-type funct to ALU control decoder.
// Ports: i_funct (IR[5:0]) in; o_alu_ctl (ALU op code), o_valid (funct supported) out.
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctl,
    output logic       o_valid
);

    always_comb begin
        o_alu_ctl = ALU_ADD;
        o_valid   = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctl = ALU_ADD;
            FN_SUB:  o_alu_ctl = ALU_SUB;
            FN_AND:  o_alu_ctl = ALU_AND;
            FN_OR:   o_alu_ctl = ALU_OR;
            FN_XOR:  o_alu_ctl = ALU_XOR;
            default: o_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the MIPS-lite datapath.
// Inputs: clk, rst (async, active high), opcode/funct from IR, ALU zero flag,
// mem_ready handshake. Outputs: alu_ctl, ALU/PC/address/register mux selects,
// PC/IR/register/memory enables, illegal pulse, state_o debug state.
// Optional macro MC_CTRL_BNE_EN adds bne (branch with pc_write = ~zero).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE  = 4'd0,
    parameter bit         ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_ctl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_r_ctl;
    logic       w_r_valid;
    logic       w_bne;

    alu_dec u_alu_dec (
        .i_funct   (funct),
        .o_alu_ctl (w_r_ctl),
        .o_valid   (w_r_valid)
    );

`ifdef MC_CTRL_BNE_EN
    assign w_bne = (opcode == OP_BNE);
`else
    assign w_bne = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= state_t'(RESET_STATE);
        else     r_state <= w_next;
    end

    assign state_o = r_state;

    // Outputs are held at zero while rst is asserted so that a reset
    // landing mid-access removes requests and enables immediately.
    always_comb begin
        w_next     = r_state;
        alu_ctl    = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_op     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        w_next    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BOFF;
                    case (opcode)
                        OP_RTYPE:              w_next = S_EXEC_R;
                        OP_ADDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
                        OP_LW, OP_SW:          w_next = S_MEM_ADDR;
                        OP_BEQ:                w_next = S_BRANCH;
                        OP_J:                  w_next = S_JUMP;
                        default:               w_next = w_bne ? S_BRANCH : S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = w_r_ctl;
                    w_next    = w_r_valid ? S_WB_R : S_ILLEGAL;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    w_next    = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctl   = (opcode == OP_ORI) ? ALU_OR : (opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
                    ext_op    = (opcode == OP_ADDI);
                    w_next    = S_WB_I;
                end
                S_WB_I: begin
                    reg_write = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                    w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    w_next   = mem_ready ? S_WB_MEM : S_MEM_RD;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    w_next     = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    w_next    = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = w_bne ? ~zero : zero;
                    w_next    = S_FETCH;
                end
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                    w_next   = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                    w_next  = ILLEGAL_HALT ? S_HALT : S_FETCH;
                end
                S_HALT:  w_next = S_HALT;
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Each instruction is expanded
// into its list of phases with expected outputs; every cycle is compared.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int C_NO = 0, C_MR = 1, C_Z = 2, C_NZ = 3;

    typedef struct {
        state_t      st;
        logic [18:0] a;
        logic [18:0] b;
        int          c;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state_o;
    logic [18:0] dv;

    int n_chk = 0;
    int n_fail = 0;
    step_t q[$];
    logic [18:0] lg[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_ctl(alu_ctl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_write(pc_write),
        .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dv = {alu_ctl, alu_src_a, alu_src_b, ext_op, pc_write, pc_src, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] o(input int alu, input int sa, input int sb, input int ext,
                                      input int pcw, input int pcs, input int ad, input int mrd,
                                      input int mwr, input int irw, input int rd, input int m2r,
                                      input int rw, input int ill);
        return {alu[3:0], sa[0], sb[1:0], ext[0], pcw[0], pcs[1:0], ad[0], mrd[0], mwr[0],
                irw[0], rd[0], m2r[0], rw[0], ill[0]};
    endfunction

    function automatic int rmap(input logic [5:0] f);
        case (f)
            6'b100000: return 0;
            6'b100010: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            6'b100110: return 4;
            default:   return -1;
        endcase
    endfunction

    task automatic push(input state_t s, input logic [18:0] a, input logic [18:0] b, input int c);
        step_t t;
        t.st = s; t.a = a; t.b = b; t.c = c;
        q.push_back(t);
    endtask

    // Expand one instruction into its phases. 'a' is the expected output when
    // the step's qualifier is true (mem_ready / zero / ~zero), 'b' otherwise.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        logic [18:0] v;
        logic [18:0] ill;
        int r;
        bit bne;
        q = {};
        ill = o(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
`ifdef MC_CTRL_BNE_EN
        bne = (op == 6'b000101);
`else
        bne = 1'b0;
`endif
        push(S_FETCH, o(0,0,1,0,1,0,0,1,0,1,0,0,0,0), o(0,0,0,0,0,0,0,1,0,0,0,0,0,0), C_MR);
        v = o(0,0,3,0,0,0,0,0,0,0,0,0,0,0);
        push(S_DECODE, v, v, C_NO);
        if (op == 6'b000000) begin
            r = rmap(fn);
            v = o(r < 0 ? 0 : r,1,0,0,0,0,0,0,0,0,0,0,0,0);
            push(S_EXEC_R, v, v, C_NO);
            if (r < 0) push(S_ILLEGAL, ill, ill, C_NO);
            else begin
                v = o(0,0,0,0,0,0,0,0,0,0,1,0,1,0);
                push(S_WB_R, v, v, C_NO);
            end
        end else if (op == 6'b001000 || op == 6'b001101 || op == 6'b001111) begin
            v = o(op == 6'b001101 ? 3 : op == 6'b001111 ? 5 : 0, 1, 2, op == 6'b001000 ? 1 : 0,
                  0,0,0,0,0,0,0,0,0,0);
            push(S_EXEC_I, v, v, C_NO);
            v = o(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
            push(S_WB_I, v, v, C_NO);
        end else if (op == 6'b100011) begin
            v = o(0,1,2,1,0,0,0,0,0,0,0,0,0,0);
            push(S_MEM_ADDR, v, v, C_NO);
            v = o(0,0,0,0,0,0,1,1,0,0,0,0,0,0);
            push(S_MEM_RD, v, v, C_MR);
            v = o(0,0,0,0,0,0,0,0,0,0,0,1,1,0);
            push(S_WB_MEM, v, v, C_NO);
        end else if (op == 6'b101011) begin
            v = o(0,1,2,1,0,0,0,0,0,0,0,0,0,0);
            push(S_MEM_ADDR, v, v, C_NO);
            v = o(0,0,0,0,0,0,1,0,1,0,0,0,0,0);
            push(S_MEM_WR, v, v, C_MR);
        end else if (op == 6'b000100 || bne) begin
            push(S_BRANCH, o(1,1,0,0,1,1,0,0,0,0,0,0,0,0), o(1,1,0,0,0,1,0,0,0,0,0,0,0,0),
                 bne ? C_NZ : C_Z);
        end else if (op == 6'b000010) begin
            v = o(0,0,0,0,1,2,0,0,0,0,0,0,0,0);
            push(S_JUMP, v, v, C_NO);
        end else begin
            push(S_ILLEGAL, ill, ill, C_NO);
        end
    endtask

    task automatic tick(input logic mr, input logic z);
        step_t s;
        logic sel;
        mem_ready = mr;
        zero = z;
        #1;
        s = q[0];
        sel = (s.c == C_MR) ? mr : (s.c == C_Z) ? z : (s.c == C_NZ) ? !z : 1'b1;
        chk("outputs", {13'd0, dv}, {13'd0, sel ? s.a : s.b});
        chk("state", {28'd0, state_o}, {28'd0, s.st});
        lg.push_back(dv);
        if (!(s.c == C_MR && !mr)) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int stalls,
                       input logic z, input bit rnd, output int cyc);
        int st;
        logic mr;
        plan(op, fn);
        lg = {};
        cyc = 0;
        st = 0;
        opcode = op;
        funct = fn;
        while (q.size() > 0 && cyc < 64) begin
            if (q[0].c == C_MR) begin
                mr = rnd ? ($urandom_range(0, 2) != 0 || st >= 6)
                         : (st >= ((q[0].st == S_FETCH) ? 0 : stalls));
                st = mr ? 0 : st + 1;
            end else begin
                mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick(mr, rnd ? 1'($urandom_range(0, 1)) : z);
            cyc++;
        end
        chk("drained", q.size(), 0);
    endtask

    function automatic int cnt(input int b);
        int n = 0;
        foreach (lg[i]) if (lg[i][b]) n++;
        return n;
    endfunction

    initial begin
        int cyc;
        logic [5:0] ops[12];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h00, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00};
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rst_outputs", {13'd0, dv}, 0);
        chk("rst_state", {28'd0, state_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        run(6'b000000, 6'b100010, 0, 1'b0, 1'b0, cyc);
        chk("sub_cycles", cyc, 4);
        chk("sub_alu_ctl", {28'd0, lg[2][18:15]}, 1);
        chk("sub_wb", {30'd0, lg[3][3], lg[3][1]}, 3);

        run(6'b100011, 6'h00, 2, 1'b0, 1'b0, cyc);
        chk("lw_cycles", cyc, 7);
        chk("lw_iord_cycles", cnt(7), 3);
        chk("lw_mem_read_cycles", cnt(6), 4);
        chk("lw_mem_to_reg", cnt(2), 1);

        run(6'b000100, 6'h00, 0, 1'b1, 1'b0, cyc);
        chk("beq_taken_cycles", cyc, 3);
        chk("beq_taken_pc", {29'd0, lg[2][10], lg[2][9:8]}, 3'b101);
        run(6'b000100, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("beq_not_taken_pcw", {31'd0, lg[2][10]}, 0);
        chk("beq_next_fetch", {28'd0, state_o}, 0);

        run(6'b001111, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("lui_exec", {25'd0, lg[2][18:15], lg[2][13:12], lg[2][11]}, {25'd0, 4'd5, 2'b10, 1'b0});
        run(6'b001101, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("ori_exec", {27'd0, lg[2][18:15], lg[2][11]}, {27'd0, 4'd3, 1'b0});

        run(6'b111111, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("ill_op_pulse", cnt(0), 1);
        chk("ill_op_no_write", cnt(1) + cnt(5), 0);
        chk("ill_op_next", {28'd0, state_o}, 0);
        run(6'b000000, 6'b000000, 0, 1'b0, 1'b0, cyc);
        chk("ill_fn_pulse", cnt(0), 1);
        chk("ill_fn_cycles", cyc, 4);
        run(6'b000101, 6'h00, 0, 1'b0, 1'b0, cyc);
`ifdef MC_CTRL_BNE_EN
        chk("bne_taken", {31'd0, lg[2][10]}, 1);
`else
        chk("bne_illegal", cnt(0), 1);
`endif
        run(6'b000010, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("j_cycles", cyc, 3);
        run(6'b101011, 6'h00, 0, 1'b0, 1'b0, cyc);
        chk("sw_cycles", cyc, 4);

        plan(6'b101011, 6'h00);
        opcode = 6'b101011;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("memwr_active", {31'd0, mem_write}, 1);
        rst = 1'b1;
        #1;
        chk("rst_drops_write", {31'd0, mem_write}, 0);
        chk("rst_async_state", {28'd0, state_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", {30'd0, mem_read, iord}, 2'b10);
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 11)];
            if (op == 6'h3f) op = 6'($urandom);
            fn = fns[$urandom_range(0, 5)];
            if (fn == 6'h00 && $urandom_range(0, 1) == 1) fn = 6'($urandom);
            run(op, fn, 0, 1'b0, 1'b1, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
